// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path.
// Define MULTICYCLE_MEM_WAIT_EN to stall memory states on mem_ready.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_FUNCT = 3'b000;
   localparam logic [2:0] ALU_ADD   = 3'b001;
   localparam logic [2:0] ALU_SUB   = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_OR    = 3'b100;
   localparam logic [2:0] ALU_SLT   = 3'b101;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

`ifdef MULTICYCLE_MEM_WAIT_EN
   localparam bit MEM_WAIT_EN = 1'b1;
`else
   localparam bit MEM_WAIT_EN = 1'b0;
`endif

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEM_ADR = 4'd3,
      S_MEM_RD  = 4'd4,
      S_MEM_WB  = 4'd5,
      S_MEM_WR  = 4'd6,
      S_R_EXEC  = 4'd7,
      S_R_WB    = 4'd8,
      S_I_EXEC  = 4'd9,
      S_I_WB    = 4'd10,
      S_BRANCH  = 4'd11,
      S_JUMP    = 4'd12
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [2:0] alu_op;
      logic       illegal_op;
   } ctrl_t;

   function automatic logic [2:0] i_alu_op(input logic [5:0] op);
      case (op)
         OP_ANDI: return ALU_AND;
         OP_ORI:  return ALU_OR;
         OP_SLTI: return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

   function automatic logic is_legal(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_main_control_if.sv
// Control bundle between the main control FSM and the datapath.
// master = control FSM side, slave = datapath side.
interface multicycle_main_control_if;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write;
   logic       pc_write_cond;
   logic       branch_ne;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       mem_to_reg;
   logic       reg_dst;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] pc_source;
   logic [2:0] alu_op;
   logic       illegal_op;

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, branch_ne, i_or_d,
      output mem_read, mem_write, ir_write, mem_to_reg,
      output reg_dst, reg_write, alu_src_a, alu_src_b,
      output pc_source, alu_op, illegal_op
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, branch_ne, i_or_d,
      input  mem_read, mem_write, ir_write, mem_to_reg,
      input  reg_dst, reg_write, alu_src_a, alu_src_b,
      input  pc_source, alu_op, illegal_op
   );
endinterface

// File: rtl/main_ctrl_decode.sv
// State (+ opcode, mem_ready) to control word decoder.
// Honours MULTICYCLE_MEM_WAIT_EN through mips_pkg::MEM_WAIT_EN.
module main_ctrl_decode
   import mips_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   logic mem_ok;
   assign mem_ok = !MEM_WAIT_EN || mem_ready;

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            // PC/IR only load once the fetch data is actually there
            ctrl.mem_read  = 1'b1;
            ctrl.ir_write  = mem_ok;
            ctrl.pc_write  = mem_ok;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_source = PCSRC_ALU;
         end
         S_DECODE: begin
            ctrl.alu_src_b  = SRCB_IMM_SH;
            ctrl.alu_op     = ALU_ADD;
            ctrl.illegal_op = !is_legal(opcode);
         end
         S_MEM_ADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_RD: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         S_R_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_R_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_I_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = i_alu_op(opcode);
         end
         S_I_WB: begin
            ctrl.reg_write = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_B;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
            ctrl.branch_ne     = (opcode == OP_BNE);
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle MIPS datapath.
// Define MULTICYCLE_MEM_WAIT_EN to hold memory states until mem_ready.
module multicycle_main_control
   import mips_pkg::*;
(
   input logic                       clk,
   input logic                       rst,
   multicycle_main_control_if.master bus
);

   state_t state;
   ctrl_t  ctrl;
   logic   mem_ok;

   assign mem_ok = !MEM_WAIT_EN || bus.mem_ready;

   main_ctrl_decode u_decode (
      .state     (state),
      .opcode    (bus.opcode),
      .mem_ready (bus.mem_ready),
      .ctrl      (ctrl)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE:    state <= S_FETCH;
            S_FETCH:   if (mem_ok) state <= S_DECODE;
            S_DECODE: begin
               case (bus.opcode)
                  OP_LW, OP_SW:   state <= S_MEM_ADR;
                  OP_RTYPE:       state <= S_R_EXEC;
                  OP_BEQ, OP_BNE: state <= S_BRANCH;
                  OP_ADDI, OP_ANDI,
                  OP_ORI, OP_SLTI: state <= S_I_EXEC;
                  OP_J:           state <= S_JUMP;
                  default:        state <= S_FETCH;
               endcase
            end
            S_MEM_ADR:
               state <= (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  if (mem_ok) state <= S_MEM_WB;
            S_MEM_WR:  if (mem_ok) state <= S_FETCH;
            S_R_EXEC:  state <= S_R_WB;
            S_I_EXEC:  state <= S_I_WB;
            default:   state <= S_FETCH;
         endcase
      end
   end

   assign bus.pc_write      = ctrl.pc_write;
   assign bus.pc_write_cond = ctrl.pc_write_cond;
   assign bus.branch_ne     = ctrl.branch_ne;
   assign bus.i_or_d        = ctrl.i_or_d;
   assign bus.mem_read      = ctrl.mem_read;
   assign bus.mem_write     = ctrl.mem_write;
   assign bus.ir_write      = ctrl.ir_write;
   assign bus.mem_to_reg    = ctrl.mem_to_reg;
   assign bus.reg_dst       = ctrl.reg_dst;
   assign bus.reg_write     = ctrl.reg_write;
   assign bus.alu_src_a     = ctrl.alu_src_a;
   assign bus.alu_src_b     = ctrl.alu_src_b;
   assign bus.pc_source     = ctrl.pc_source;
   assign bus.alu_op        = ctrl.alu_op;
   assign bus.illegal_op    = ctrl.illegal_op;

endmodule
